// File: rtl/csr_issue_ctrl.sv
// Serializing issue controller for CSR micro-ops: waits for ROB head, issues to the CSRU, writes back.
// Optional watchdog on the CSRU handshake is enabled with `define CSR_ISSUE_TIMEOUT_EN.
module csr_issue_ctrl (
  input  logic        Clk,
  input  logic        Rest,
  input  logic        InValid,
  output logic        InReady,
  input  logic [7:0]  InMicOp,
  input  logic [31:0] InSrc0,
  input  logic [31:0] InSrc1,
  input  logic [6:0]  InPhyDst,
  input  logic [5:0]  InRobTag,
  input  logic        RobHeadValid,
  input  logic [5:0]  RobHeadTag,
  input  logic        Flush,
  output logic        CsruValid,
  output logic [7:0]  CsruMicOp,
  output logic [31:0] CsruSrc0,
  output logic [31:0] CsruSrc1,
  input  logic        CsruDone,
  input  logic [31:0] CsruDate,
  input  logic        CsruExcp,
  input  logic [6:0]  CsruExcpCode,
  output logic        WbValid,
  output logic [6:0]  WbAddr,
  output logic [31:0] WbDate,
  output logic [5:0]  WbRobTag,
  output logic        WbExcp,
  output logic [6:0]  WbExcpCode,
  output logic        Busy,
  output logic        TimeoutErr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HEAD, S_ISSUE, S_WAIT_DONE, S_DRAIN, S_WB
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  micop_q;
  logic [31:0] src0_q, src1_q, date_q;
  logic [6:0]  dst_q, code_q;
  logic [5:0]  tag_q;
  logic        excp_q;
  logic        accept, tmo, cap_done;

  assign accept   = (state_q == S_IDLE) && InValid && !Flush;
  assign cap_done = (state_q == S_WAIT_DONE) && !Flush && CsruDone;

`ifdef CSR_ISSUE_TIMEOUT_EN
  logic [3:0] wdog_q, wdog_d;

  // Fires on the cycle the watchdog would reach 15; a flush in WAIT_DONE wins over it.
  assign tmo = !CsruDone && (wdog_q == 4'd14) &&
               ((state_q == S_DRAIN) || ((state_q == S_WAIT_DONE) && !Flush));

  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q)
      wdog_d = 4'd0;
    else if (((state_q == S_WAIT_DONE) || (state_q == S_DRAIN)) && !CsruDone)
      wdog_d = wdog_q + 4'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Rest) wdog_q <= 4'd0;
    else       wdog_q <= wdog_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (accept) state_d = S_WAIT_HEAD;
      S_WAIT_HEAD: begin
        if (Flush)                                          state_d = S_IDLE;
        else if (RobHeadValid && (RobHeadTag == tag_q))     state_d = S_ISSUE;
      end
      S_ISSUE:     state_d = Flush ? S_DRAIN : S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (Flush)                  state_d = CsruDone ? S_IDLE : S_DRAIN;
        else if (CsruDone || tmo)   state_d = S_WB;
      end
      S_DRAIN:     if (CsruDone || tmo) state_d = S_IDLE;
      S_WB:        state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rest) begin
      state_q <= S_IDLE;
      micop_q <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      dst_q   <= '0;
      tag_q   <= '0;
      date_q  <= '0;
      excp_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        micop_q <= InMicOp;
        src0_q  <= InSrc0;
        src1_q  <= InSrc1;
        dst_q   <= InPhyDst;
        tag_q   <= InRobTag;
      end
      if (cap_done) begin
        date_q <= CsruDate;
        excp_q <= CsruExcp;
        code_q <= CsruExcpCode;
      end else if (tmo && (state_q == S_WAIT_DONE)) begin
        date_q <= '0;
        excp_q <= 1'b1;
        code_q <= 7'h7F;
      end
    end
  end

  assign InReady    = (state_q == S_IDLE);
  assign Busy       = (state_q != S_IDLE);
  assign CsruValid  = (state_q == S_ISSUE);
  assign WbValid    = (state_q == S_WB) && !Flush;
  assign TimeoutErr = tmo;
  assign CsruMicOp  = micop_q;
  assign CsruSrc0   = src0_q;
  assign CsruSrc1   = src1_q;
  assign WbAddr     = dst_q;
  assign WbRobTag   = tag_q;
  assign WbDate     = date_q;
  assign WbExcp     = excp_q;
  assign WbExcpCode = code_q;

endmodule

// File: doc/csr_issue_ctrl.md
CSR_ISSUE_CTRL -- requirements
Module: csr_issue_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: Clk (input, 1, rising-edge clock) and Rest (input, 1, synchronous active-low reset).
REQ-002 SHALL have the RS-side ports: InValid (in, 1, CSR op offered); InReady (out, 1, op accepted when high); InMicOp (in, 8, micro-opcode); InSrc0 and InSrc1 (in, 32 each, operands); InPhyDst (in, 7, rename dest); InRobTag (in, 6, ROB index).
REQ-003 SHALL have the ROB-side ports: RobHeadValid (in, 1); RobHeadTag (in, 6, ROB head index); Flush (in, 1, pipeline flush).
REQ-004 SHALL have the Csru-side ports: CsruValid (out, 1, issue pulse); CsruMicOp (out, 8); CsruSrc0 and CsruSrc1 (out, 32 each); CsruDone (in, 1); CsruDate (in, 32, result); CsruExcp (in, 1); CsruExcpCode (in, 7).
REQ-005 SHALL have the writeback ports: WbValid (out, 1); WbAddr (out, 7); WbDate (out, 32); WbRobTag (out, 6); WbExcp (out, 1); WbExcpCode (out, 7); Busy (out, 1, state not IDLE); TimeoutErr (out, 1).

Function
REQ-006 SHALL implement an FSM with the states IDLE, WAIT_HEAD, ISSUE, WAIT_DONE, DRAIN and WB; Busy is 1 in every state except IDLE.
REQ-007 SHALL drive InReady = 1 in IDLE only; an op is accepted when InValid & InReady & !Flush, latching all In* fields and moving to WAIT_HEAD.
REQ-008 WAIT_HEAD: SHALL move to ISSUE in the cycle after sampling RobHeadValid=1 with RobHeadTag equal to the latched tag; otherwise it stays in WAIT_HEAD.
REQ-009 ISSUE: SHALL drive CsruValid=1 for exactly one cycle with the latched MicOp and Src0/Src1, then move to WAIT_DONE.
REQ-010 CsruDone SHALL be sampled only in WAIT_DONE and DRAIN; CsruDone asserted during the ISSUE cycle is ignored.
REQ-011 WAIT_DONE: on CsruDone, SHALL latch CsruDate, CsruExcp and CsruExcpCode and move to WB.
REQ-012 WB: SHALL drive WbValid=1 for exactly one cycle with WbAddr and WbRobTag taken from the latched fields and WbDate, WbExcp and WbExcpCode taken from the Csru capture, then move to IDLE.
REQ-013 Outside their pulse cycles, CsruValid=0 and WbValid=0; the data outputs hold their last latched values.
REQ-014 Flush in IDLE or WAIT_HEAD SHALL drop the op and go to IDLE in the next cycle, with no Csru issue.
REQ-015 Flush in ISSUE SHALL still complete the CsruValid pulse, then go to DRAIN; Flush in WAIT_DONE SHALL go to DRAIN, unless CsruDone is high in that same cycle, in which case the FSM goes to IDLE.
REQ-016 DRAIN: SHALL wait for CsruDone, then go to IDLE with no writeback.
REQ-017 Flush in WB SHALL force WbValid=0 in that cycle, and the FSM goes to IDLE.
REQ-018 Flush SHALL take priority over every other transition in the same cycle.
REQ-019 SHALL hold at most one CSR op in flight, so CSR ops are strictly serialized.

Reset
REQ-020 While Rest=0 at a Clk edge, the state SHALL become IDLE, with InReady=1, CsruValid=0, WbValid=0, WbExcp=0, TimeoutErr=0, Busy=0, and all data and code outputs at 0.
REQ-021 Reset asserted in any state SHALL abandon the op; no Csru issue or writeback occurs afterwards.

Configuration
REQ-022 With macro CSR_ISSUE_TIMEOUT_EN defined, the block SHALL use a 4-bit watchdog that clears on entry to WAIT_DONE or DRAIN and increments each cycle without CsruDone.
REQ-023 When the watchdog reaches 15 with no CsruDone in WAIT_DONE, the FSM SHALL go to WB with WbExcp=1, WbExcpCode=7'h7F and WbDate=0, and TimeoutErr SHALL pulse for 1 cycle.
REQ-024 When the watchdog reaches 15 in DRAIN, the FSM SHALL go to IDLE and TimeoutErr SHALL pulse for 1 cycle.
REQ-025 Without CSR_ISSUE_TIMEOUT_EN, the block SHALL have no counter logic, TimeoutErr SHALL be tied to 0, and WAIT_DONE and DRAIN wait indefinitely.

Verification
REQ-026 Basic: accept an op with tag 5, PhyDst 7'h12, Src0 32'hA5A5_0000; RobHeadTag=5 is valid 3 cycles later; CsruDone comes 2 cycles after issue with Date 32'h1234 -> exactly one CsruValid pulse, then WbValid with WbAddr 7'h12, WbDate 32'h1234, WbRobTag 5.
REQ-027 Head mismatch: RobHeadTag=4 is held for 10 cycles -> no CsruValid and InReady=0 throughout; switching to tag 5 -> issue follows.
REQ-028 Flush during WAIT_DONE, with CsruDone arriving 3 cycles later -> no WbValid; InReady returns to 1 in the cycle after the done.
REQ-029 Simultaneous InValid and Flush in IDLE -> op not accepted and Busy stays 0; CsruDone=1 in the ISSUE cycle -> ignored.
REQ-030 Exception: CsruExcp=1 with code 7'h0B -> WbExcp=1 and WbExcpCode=7'h0B.
REQ-031 With CSR_ISSUE_TIMEOUT_EN, CsruDone never asserted -> TimeoutErr pulses on the 15th cycle in WAIT_DONE, followed by WbValid with WbExcpCode=7'h7F.
REQ-032 Reset in WAIT_HEAD -> the FSM is in IDLE in the next cycle, and a later head match produces no issue.
